reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_if.sv | 30 +++
 rtl/reg_file_param.sv | 75 +++++++
 tb/tb_reg_file_param.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: register-file access bus between a master and the register file.
// Requests (master -> slave): clr_req, we, dest_sel, rs_addr, rt_addr, rd_addr, wdata.
// Responses (slave -> master): rs_data, rt_data, save_data, busy, wr_drop.
interface reg_file_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              clr_req;
    logic              we;
    logic              dest_sel;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] save_data;
    logic              busy;
    logic              wr_drop;

    modport master (
        output clr_req, we, dest_sel, rs_addr, rt_addr, rd_addr, wdata,
        input  rs_data, rt_data, save_data, busy, wr_drop
    );

    modport slave (
        input  clr_req, we, dest_sel, rs_addr, rt_addr, rd_addr, wdata,
        output rs_data, rt_data, save_data, busy, wr_drop
    );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: 2**ADDR_W x DATA_W register file with two combinational read ports and a sweep clear.
// Ports: clk (rising-edge clock), rst (asynchronous active-high reset),
//        bus (reg_file_if.slave: write/clear requests in; rs/rt/save read data, busy and wr_drop out).
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input logic      clk,
    input logic      rst,
    reg_file_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_wr_drop;
    logic              w_busy;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_rs_arr, w_rt_arr;

    assign w_busy  = r_state == CLEAR;
    assign w_waddr = bus.dest_sel ? bus.rs_addr : bus.rd_addr;
    // Writes to the hardwired zero register are silently discarded, not flagged as drops.
    assign w_wr_en = bus.we && !w_busy && !(ZERO_REG != 0 && w_waddr == '0);

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && bus.clr_req)
            w_next = CLEAR;
        else if (r_state == CLEAR && r_idx == '1)
            w_next = IDLE;
    end

    // The sweep index sits at 0 while idle, so entering CLEAR starts from register 0;
    // it wraps naturally at the top of the ADDR_W range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_wr_drop <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_state   <= w_next;
            r_idx     <= w_busy ? r_idx + 1'b1 : '0;
            r_wr_drop <= bus.we && w_busy;
            if (w_busy)
                r_regs[r_idx] <= '0;
            else if (w_wr_en)
                r_regs[w_waddr] <= bus.wdata;
        end
    end

    assign w_rs_arr = (ZERO_REG != 0 && bus.rs_addr == '0) ? '0 : r_regs[bus.rs_addr];
    assign w_rt_arr = (ZERO_REG != 0 && bus.rt_addr == '0) ? '0 : r_regs[bus.rt_addr];

`ifdef REG_FILE_BYPASS_EN
    // w_wr_en already excludes index 0 when it is hardwired, so no forwarding happens there.
    assign bus.rs_data = (w_wr_en && w_waddr == bus.rs_addr) ? bus.wdata : w_rs_arr;
    assign bus.rt_data = (w_wr_en && w_waddr == bus.rt_addr) ? bus.wdata : w_rt_arr;
`else
    assign bus.rs_data = w_rs_arr;
    assign bus.rt_data = w_rt_arr;
`endif

    assign bus.save_data = bus.rs_data;
    assign bus.busy      = w_busy;
    assign bus.wr_drop   = r_wr_drop;
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed self-checking bench for reg_file_param (default and ZERO_REG=1 instances).
module tb_reg_file_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(8), .ADDR_W(3)) bus ();
    reg_file_if #(.DATA_W(8), .ADDR_W(3)) zb ();

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (.clk(clk), .rst(rst), .bus(bus));
    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (.clk(clk), .rst(rst), .bus(zb));

    task automatic wr(input logic ds, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.we = 1'b1;
        bus.dest_sel = ds;
        if (ds) bus.rs_addr = a;
        else bus.rd_addr = a;
        bus.wdata = d;
        @(negedge clk);
        bus.we = 1'b0;
        bus.dest_sel = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rs_addr = 3'(i);
            bus.rt_addr = 3'(i);
            #1;
            checks++;
            if (bus.rs_data !== 8'h00) begin failures++; $display("FAIL reset_rs[%0d] got=%h exp=00", i, bus.rs_data); end
            checks++;
            if (bus.rt_data !== 8'h00) begin failures++; $display("FAIL reset_rt[%0d] got=%h exp=00", i, bus.rt_data); end
        end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.wr_drop !== 1'b0) begin failures++; $display("FAIL reset_wr_drop got=%b exp=0", bus.wr_drop); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write;
        wr(1'b0, 3'd5, 8'hA5);
        bus.rs_addr = 3'd5;
        #1;
        checks++;
        if (bus.rs_data !== 8'hA5) begin failures++; $display("FAIL write_rd_rs got=%h exp=a5", bus.rs_data); end
        checks++;
        if (bus.save_data !== 8'hA5) begin failures++; $display("FAIL write_save got=%h exp=a5", bus.save_data); end
        wr(1'b1, 3'd2, 8'h3C);
        bus.rs_addr = 3'd2;
        bus.rt_addr = 3'd5;
        #1;
        checks++;
        if (bus.rs_data !== 8'h3C) begin failures++; $display("FAIL write_rs_dest got=%h exp=3c", bus.rs_data); end
        checks++;
        if (bus.rt_data !== 8'hA5) begin failures++; $display("FAIL write_reg5_kept got=%h exp=a5", bus.rt_data); end
    endtask

    task automatic test_bypass;
        logic [7:0] exp_now;
`ifdef REG_FILE_BYPASS_EN
        exp_now = 8'h5A;
`else
        exp_now = 8'h00;
`endif
        @(negedge clk);
        bus.we = 1'b1;
        bus.dest_sel = 1'b0;
        bus.rd_addr = 3'd3;
        bus.rt_addr = 3'd3;
        bus.wdata = 8'h5A;
        #1;
        checks++;
        if (bus.rt_data !== exp_now) begin failures++; $display("FAIL bypass_same_cycle got=%h exp=%h", bus.rt_data, exp_now); end
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        checks++;
        if (bus.rt_data !== 8'h5A) begin failures++; $display("FAIL bypass_next_cycle got=%h exp=5a", bus.rt_data); end
    endtask

    task automatic test_sweep;
        int n;
        for (int i = 1; i < 8; i++) wr(1'b0, 3'(i), 8'(i * 17));
        bus.rs_addr = 3'd7;
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            if (n == 3) begin
                bus.we = 1'b1;
                bus.rd_addr = 3'd4;
                bus.wdata = 8'hFF;
                bus.clr_req = 1'b1;
            end
            if (n == 4) begin
                bus.we = 1'b0;
                bus.clr_req = 1'b0;
                bus.rt_addr = 3'd4;
                #1;
                checks++;
                if (bus.wr_drop !== 1'b1) begin failures++; $display("FAIL sweep_wr_drop_set got=%b exp=1", bus.wr_drop); end
                checks++;
                if (bus.rt_data !== 8'h44) begin failures++; $display("FAIL sweep_drop_no_write got=%h exp=44", bus.rt_data); end
            end
            if (n == 5) begin
                #1;
                checks++;
                if (bus.wr_drop !== 1'b0) begin failures++; $display("FAIL sweep_wr_drop_one_cycle got=%b exp=0", bus.wr_drop); end
            end
            if (n == 6) begin
                bus.rt_addr = 3'd1;
                #1;
                checks++;
                if (bus.rt_data !== 8'h00) begin failures++; $display("FAIL sweep_reg1_cleared got=%h exp=00", bus.rt_data); end
            end
            if (n == 8) begin
                #1;
                checks++;
                if (bus.rs_data !== 8'h77) begin failures++; $display("FAIL sweep_reg7_unswept got=%h exp=77", bus.rs_data); end
            end
            @(negedge clk);
        end
        checks++;
        if (n !== 8) begin failures++; $display("FAIL sweep_busy_cycles got=%0d exp=8", n); end
        for (int i = 0; i < 8; i++) begin
            bus.rt_addr = 3'(i);
            #1;
            checks++;
            if (bus.rt_data !== 8'h00) begin failures++; $display("FAIL sweep_after_reg[%0d] got=%h exp=00", i, bus.rt_data); end
        end
    endtask

    task automatic test_write_clr;
        int n;
        @(negedge clk);
        bus.we = 1'b1;
        bus.dest_sel = 1'b0;
        bus.rd_addr = 3'd6;
        bus.wdata = 8'h66;
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
        bus.clr_req = 1'b0;
        bus.rs_addr = 3'd6;
        #1;
        checks++;
        if (bus.rs_data !== 8'h66) begin failures++; $display("FAIL wrclr_write_committed got=%h exp=66", bus.rs_data); end
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL wrclr_busy got=%b exp=1", bus.busy); end
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 8) begin failures++; $display("FAIL wrclr_busy_cycles got=%0d exp=8", n); end
        #1;
        checks++;
        if (bus.rs_data !== 8'h00) begin failures++; $display("FAIL wrclr_reg6_swept got=%h exp=00", bus.rs_data); end
    endtask

    task automatic test_reset_mid;
        wr(1'b0, 3'd5, 8'h55);
        bus.rs_addr = 3'd5;
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.rs_data !== 8'h00) begin failures++; $display("FAIL rstmid_reg5 got=%h exp=00", bus.rs_data); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle_after got=%b exp=0", bus.busy); end
        checks++;
        if (bus.rs_data !== 8'h00) begin failures++; $display("FAIL rstmid_reg5_after got=%h exp=00", bus.rs_data); end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        zb.we = 1'b1;
        zb.dest_sel = 1'b0;
        zb.rd_addr = 3'd0;
        zb.rs_addr = 3'd0;
        zb.wdata = 8'h99;
        #1;
        checks++;
        if (zb.rs_data !== 8'h00) begin failures++; $display("FAIL zero_same_cycle got=%h exp=00", zb.rs_data); end
        @(negedge clk);
        zb.we = 1'b0;
        #1;
        checks++;
        if (zb.rs_data !== 8'h00) begin failures++; $display("FAIL zero_after_write got=%h exp=00", zb.rs_data); end
        checks++;
        if (zb.wr_drop !== 1'b0) begin failures++; $display("FAIL zero_no_wr_drop got=%b exp=0", zb.wr_drop); end
        @(negedge clk);
        zb.we = 1'b1;
        zb.rd_addr = 3'd1;
        zb.wdata = 8'h12;
        @(negedge clk);
        zb.we = 1'b0;
        zb.rt_addr = 3'd1;
        #1;
        checks++;
        if (zb.rt_data !== 8'h12) begin failures++; $display("FAIL zero_reg1_write got=%h exp=12", zb.rt_data); end
        wr(1'b0, 3'd0, 8'h99);
        bus.rs_addr = 3'd0;
        #1;
        checks++;
        if (bus.rs_data !== 8'h99) begin failures++; $display("FAIL nozero_reg0_write got=%h exp=99", bus.rs_data); end
    endtask

    initial begin
        bus.clr_req = 1'b0; bus.we = 1'b0; bus.dest_sel = 1'b0;
        bus.rs_addr = '0; bus.rt_addr = '0; bus.rd_addr = '0; bus.wdata = '0;
        zb.clr_req = 1'b0; zb.we = 1'b0; zb.dest_sel = 1'b0;
        zb.rs_addr = '0; zb.rt_addr = '0; zb.rd_addr = '0; zb.wdata = '0;
        test_reset;
        test_write;
        test_bypass;
        test_sweep;
        test_write_clr;
        test_reset_mid;
        test_zero_reg;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
